// File: rtl/async_xfer_launcher.sv
// clk1-side launcher: buffers words in a small FIFO and runs one req1/busy handshake per word; ASYNC_XFER_TIMEOUT_EN adds a sticky watchdog.
// Latency: beat accepted in cycle N is loaded into xfer_data at the N+1 edge (req1 in N+2); s_ready = FIFO not full.
module async_xfer_launcher #(
    parameter int DATA_WIDTH     = 24,
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_WIDTH      = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk1,
    input  logic                  rst_n1,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  req1,
    input  logic                  busy,
    output logic [DATA_WIDTH-1:0] xfer_data,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  fifo_cnt,
    output logic                  timeout_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ARM  = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2 ||
        CNT_WIDTH < $clog2(FIFO_DEPTH + 1)) begin : g_param_check
        $error("async_xfer_launcher: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [DATA_WIDTH-1:0] xfer_q;
    logic                  done_q;
    logic                  done_d;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  tmo_hit;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    // A full FIFO refuses data even when a pop happens in the same cycle.
    assign push  = s_valid && !full;
    assign pop   = (state_q == ST_IDLE) && !empty && !busy;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (pop) state_d = ST_REQ;
            ST_REQ:  state_d = ST_ARM;
            ST_ARM: begin
                if (tmo_hit)   state_d = ST_IDLE;
                else if (busy) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completing handshake wins over a watchdog expiring in the same cycle.
                if (!busy) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clk1 or negedge rst_n1) begin
        if (!rst_n1) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            xfer_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                xfer_q   <= mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

`ifdef ASYNC_XFER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_d;
    logic             tmo_err_q;

    // Counts cycles since launch: zero in REQ, so the watchdog trips TIMEOUT_CYCLES after req1.
    assign tmo_cnt_d = (state_q == ST_IDLE) ? '0 : tmo_cnt_q + 1'b1;
    assign tmo_hit   = ((state_q == ST_ARM) || (state_q == ST_WAIT)) && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk1 or negedge rst_n1) begin
        if (!rst_n1) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_hit && ((state_q == ST_ARM) || busy)) tmo_err_q <= 1'b1;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign s_ready   = !full;
    assign req1      = (state_q == ST_REQ);
    assign xfer_data = xfer_q;
    assign done      = done_q;
    assign fifo_cnt  = cnt_q;

endmodule

// File: tb/tb_async_xfer_launcher.sv
// Bench for async_xfer_launcher: reset values, table-driven fill/back-pressure, directed corner cases, randomized stream.
module tb_async_xfer_launcher;

    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int TMO   = 16;

    logic          clk1;
    logic          rst_n1;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          req1;
    logic          busy;
    logic [DW-1:0] xfer_data;
    logic          done;
    logic [CW-1:0] fifo_cnt;
    logic          timeout_err;

    async_xfer_launcher #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .CNT_WIDTH     (CW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk1       (clk1),
        .rst_n1     (rst_n1),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .req1       (req1),
        .busy       (busy),
        .xfer_data  (xfer_data),
        .done       (done),
        .fifo_cnt   (fifo_cnt),
        .timeout_err(timeout_err)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    // Handshake partner model: raises busy the cycle after req1, holds it for a set number of cycles.
    logic busy_man;
    logic bm_busy;
    bit   bm_mode;
    bit   bm_rand;
    int   bm_len;
    int   bm_left;
    bit   bm_req_seen;

    assign busy = bm_mode ? bm_busy : busy_man;

    always @(posedge clk1) begin
        #1;
        if (!bm_mode) begin
            bm_busy = 1'b0;
            bm_left = 0;
        end else if (bm_left > 0) begin
            bm_left--;
            if (bm_left == 0) bm_busy = 1'b0;
        end else if (bm_req_seen) begin
            bm_busy = 1'b1;
            bm_left = bm_rand ? int'($urandom_range(3, 20)) : bm_len;
        end
        bm_req_seen = 1'b0;
    end

    // Scoreboard: words in flight through the FIFO, launch order, occupancy and pulse bookkeeping.
    logic [DW-1:0] mq[$];
    bit            mon_en;
    bit            pend_push;
    logic [DW-1:0] pend_dat;
    bit            inflight;
    logic [DW-1:0] last_word;
    int            n_req;
    int            n_done;

    always @(negedge clk1) begin
        if (req1 === 1'b1) bm_req_seen = 1'b1;
        if (mon_en) begin
            if (pend_push) mq.push_back(pend_dat);
            pend_push = 1'b0;
            if (req1) begin
                chk("req1_while_busy", busy, 1'b0);
                chk("req1_second_inflight", inflight, 1'b0);
                chk("req1_queue_nonempty", mq.size() != 0, 1'b1);
                if (mq.size() != 0) begin
                    last_word = mq.pop_front();
                    chk("launch_xfer_data", xfer_data, last_word);
                end
                n_req++;
                inflight = 1'b1;
            end else if (n_req > 0) begin
                chk("xfer_data_hold", xfer_data, last_word);
            end
            if (done) begin
                chk("done_without_transfer", inflight, 1'b1);
                inflight = 1'b0;
                n_done++;
            end
            chk("mon_fifo_cnt", fifo_cnt, mq.size());
            chk("mon_s_ready", s_ready, mq.size() < DEPTH);
            if (s_valid && mq.size() < DEPTH) begin
                pend_push = 1'b1;
                pend_dat  = s_data;
            end
        end
    end

    task automatic mon_start();
        mq.delete();
        pend_push = 1'b0;
        inflight  = 1'b0;
        n_req     = 0;
        n_done    = 0;
        mon_en    = 1'b1;
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        bm_mode  = 1'b0;
        bm_rand  = 1'b0;
        busy_man = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        rst_n1   = 1'b0;
        repeat (2) @(posedge clk1);
        #1 rst_n1 = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1'b1);
        chk({tag, "_req1"}, req1, 1'b0);
        chk({tag, "_xfer_data"}, xfer_data, '0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_fifo_cnt"}, fifo_cnt, '0);
        chk({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    typedef struct {
        logic          sv;
        logic [DW-1:0] d;
        logic          bz;
        logic          rdy;
        logic [CW-1:0] cnt;
        logic          rq;
        logic          dn;
        logic [DW-1:0] xd;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int req_k;
        int terr_k;
        int bad;
        int t;
        bit acc;
        bit saw_done;
        bit saw_req;
        bit got_done;
        bit got_req;
        logic [DW-1:0] got_xd;

        // Fill/back-pressure: the first word launches, busy never rises so it stays held, four more fill the FIFO.
        //             sv    data        bz    rdy   cnt   rq    dn    xfer_data
        tbl[0]  = '{1'b1, 24'h000100, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 24'h000000};
        tbl[1]  = '{1'b1, 24'h000101, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 24'h000000};
        tbl[2]  = '{1'b1, 24'h000102, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 24'h000100};
        tbl[3]  = '{1'b1, 24'h000103, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 24'h000100};
        tbl[4]  = '{1'b1, 24'h000104, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 24'h000100};
        tbl[5]  = '{1'b1, 24'h000105, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 24'h000100};
        tbl[6]  = '{1'b1, 24'h000105, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 24'h000100};
        tbl[7]  = '{1'b1, 24'h000105, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 24'h000100};
        tbl[8]  = '{1'b1, 24'h000105, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 24'h000100};
        tbl[9]  = '{1'b1, 24'h000105, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 24'h000101};
        tbl[10] = '{1'b0, 24'h000000, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 24'h000101};

        s_valid  = 1'b0;
        s_data   = '0;
        busy_man = 1'b0;
        bm_mode  = 1'b0;
        bm_rand  = 1'b0;
        bm_len   = 8;
        mon_en   = 1'b0;
        rst_n1   = 1'b0;

        // Reset values, during and just after reset.
        #2;
        chk_reset_vals("rst");
        repeat (2) @(posedge clk1);
        #1 rst_n1 = 1'b1;
        @(negedge clk1);
        chk_reset_vals("post_rst");
        @(posedge clk1);
        #1;

        // Single word, busy held 8 cycles starting the cycle after req1.
        bm_mode = 1'b1;
        bm_len  = 8;
        mon_start();
        s_valid = 1'b1;
        s_data  = 24'hABCDEF;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk1);
            chk($sformatf("single_c%0d_req1", c), req1, c == 2);
            chk($sformatf("single_c%0d_done", c), done, c == 12);
            chk($sformatf("single_c%0d_cnt", c), fifo_cnt, c == 1);
            if (c >= 2) chk($sformatf("single_c%0d_xfer", c), xfer_data, 24'hABCDEF);
            @(posedge clk1);
            #1 s_valid = 1'b0;
        end
        chk("single_req_count", n_req, 1);
        chk("single_done_count", n_done, 1);

        // Table-driven fill and back-pressure with busy driven directly.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            s_valid  = tbl[i].sv;
            s_data   = tbl[i].d;
            busy_man = tbl[i].bz;
            @(negedge clk1);
            chk($sformatf("tbl%0d_s_ready", i), s_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_fifo_cnt", i), fifo_cnt, tbl[i].cnt);
            chk($sformatf("tbl%0d_req1", i), req1, tbl[i].rq);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
            chk($sformatf("tbl%0d_xfer", i), xfer_data, tbl[i].xd);
            @(posedge clk1);
            #1;
        end
        s_valid = 1'b0;

        // Busy already high in IDLE: nothing launches until it drops.
        do_reset();
        busy_man = 1'b1;
        mon_start();
        s_valid = 1'b1;
        s_data  = 24'h5A5A5A;
        @(posedge clk1);
        #1 s_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk1);
            chk("busy_high_no_req1", req1, 1'b0);
            @(posedge clk1);
            #1;
        end
        busy_man = 1'b0;
        req_k = -1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk1);
            if (req1 && req_k < 0) req_k = k;
            @(posedge clk1);
            #1;
        end
        chk("busy_release_req_delay", (req_k >= 1) && (req_k <= 2), 1'b1);
        chk("busy_release_req_count", n_req, 1);

        // Reset while waiting on busy with two words still queued.
        do_reset();
        bm_mode = 1'b1;
        bm_len  = 20;
        mon_start();
        for (int w = 0; w < 3; w++) begin
            s_valid = 1'b1;
            s_data  = 24'hC0DE00 + DW'(w);
            @(posedge clk1);
            #1;
        end
        s_valid = 1'b0;
        t = 0;
        while (!busy && t < 30) begin
            @(posedge clk1);
            #1 t++;
        end
        if (!busy) fail("rst_wait_busy_rise");
        repeat (3) @(negedge clk1);
        chk("rst_wait_cnt_before", fifo_cnt, 2);
        #2;
        rst_n1  = 1'b0;
        mon_en  = 1'b0;
        bm_mode = 1'b0;
        #1;
        chk_reset_vals("rst_wait");
        repeat (2) @(posedge clk1);
        #1 rst_n1 = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk1);
            if (done || req1 || fifo_cnt != 0) bad++;
        end
        chk("rst_wait_quiet_after", bad, 0);
        @(posedge clk1);
        #1;

        // Randomized stream of 16 words against random busy lengths.
        do_reset();
        bm_mode = 1'b1;
        bm_rand = 1'b1;
        mon_start();
        for (int w = 0; w < 16; w++) begin
            int tries;
            tries   = 0;
            acc     = 1'b0;
            s_valid = 1'b1;
            s_data  = DW'(w);
            while (!acc && tries < 300) begin
                @(negedge clk1);
                acc = s_ready;
                @(posedge clk1);
                #1 tries++;
            end
            s_valid = 1'b0;
            if (!acc) fail("stream_accept");
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk1);
                #1;
            end
        end
        t = 0;
        while (n_done < 16 && t < 2000) begin
            @(posedge clk1);
            #1 t++;
        end
        @(negedge clk1);
        chk("stream_req_count", n_req, 16);
        chk("stream_done_count", n_done, 16);
        chk("stream_queue_drained", mq.size(), 0);
        @(posedge clk1);
        #1;

        // Busy stuck high after a launch, second word queued behind it.
        do_reset();
        s_valid = 1'b1;
        s_data  = 24'hAAA001;
        @(posedge clk1);
        #1 s_data = 24'hAAA002;
        @(posedge clk1);
        #1 s_valid = 1'b0;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 10) begin
            @(negedge clk1);
            acc = req1;
            @(posedge clk1);
            #1 t++;
        end
        if (!acc) fail("stuck_first_req1");
        busy_man = 1'b1;
        terr_k   = -1;
        saw_done = 1'b0;
        saw_req  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk1);
            if (timeout_err && terr_k < 0) terr_k = k;
            if (done) saw_done = 1'b1;
            if (req1) saw_req = 1'b1;
            @(posedge clk1);
            #1;
        end
        chk("stuck_no_done", saw_done, 1'b0);
        chk("stuck_no_req1", saw_req, 1'b0);
`ifdef ASYNC_XFER_TIMEOUT_EN
        chk("tmo_err_cycle", terr_k, 16);
`else
        chk("no_tmo_err", terr_k, -1);
`endif
        busy_man = 1'b0;
        got_done = 1'b0;
        got_req  = 1'b0;
        got_xd   = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk1);
            if (done) got_done = 1'b1;
            if (req1 && !got_req) begin
                got_req = 1'b1;
                got_xd  = xfer_data;
            end
            @(posedge clk1);
            #1;
        end
        chk("stuck_next_req1", got_req, 1'b1);
        chk("stuck_next_xfer", got_xd, 24'hAAA002);
`ifdef ASYNC_XFER_TIMEOUT_EN
        chk("tmo_dropped_no_done", got_done, 1'b0);
        chk("tmo_err_sticky", timeout_err, 1'b1);
`else
        chk("stuck_release_done", got_done, 1'b1);
        chk("no_tmo_err_after", timeout_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
